// File: rtl/axi_w_pkg.sv
// Shared types and constants for the AXI4-Lite write packer.
package axi_w_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Number of byte-offset address bits inside one data word.
  function automatic int strb_off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_w_flush_timer.sv
// Idle counter that flags when a partial word has sat untouched long enough.
module axi_w_flush_timer #(
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (FLUSH_TIMEOUT == 0) begin : g_off
      logic unused_s;
      assign unused_s = clk ^ rst ^ clear ^ enable;
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(FLUSH_TIMEOUT - 1);
      localparam logic [CW-1:0] ONE  = CW'(1);

      logic [CW-1:0] count_q, count_d;

      // Saturating idle count; expiry fires on the cycle that would reach the limit.
      always_comb begin
        if (clear) begin
          count_d = '0;
        end else if (enable && (count_q != LAST)) begin
          count_d = count_q + ONE;
        end else begin
          count_d = count_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expire = enable && !clear && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/axi_lite_w_packer.sv
// AXI4-Lite write adapter merging partial-strobe writes into full words.
// Optional sticky error forwarding: define AXI_W_PACKER_BRESP_FWD_EN.
module axi_lite_w_packer
  import axi_w_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = strb_off_bits(DATA_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [STRB_W-1:0]   buf_strb_q, buf_strb_d;
  logic                s_ready_q, s_ready_d;
  logic                s_bvalid_q, s_bvalid_d;
  logic [1:0]          s_bresp_q, s_bresp_d;
  logic                m_awvalid_q, m_awvalid_d;
  logic                m_wvalid_q, m_wvalid_d;
  logic                m_bready_q, m_bready_d;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
  logic [1:0]          err_q, err_d;
`endif

  logic [ADDR_W-1:0]   waddr_s;
  logic [DATA_W-1:0]   merge_data_s;
  logic [STRB_W-1:0]   merge_strb_s;
  logic                handshake_s;
  logic                eligible_s;
  logic                tmr_clear_s;
  logic                tmr_enable_s;
  logic                tmr_expire_s;
  logic                unused_s;

  assign waddr_s      = s_axi_awaddr & WORD_MASK;
  assign handshake_s  = s_ready_q && s_axi_awvalid && s_axi_wvalid;
  assign eligible_s   = ((state_q == IDLE) || (state_q == FILL)) && s_axi_awvalid &&
                        s_axi_wvalid && !s_bvalid_q && !s_ready_q;
  assign tmr_clear_s  = handshake_s || (state_q != FILL);
  assign tmr_enable_s = (state_q == FILL) && !handshake_s;

  axi_w_flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear_s),
    .enable(tmr_enable_s),
    .expire(tmr_expire_s)
  );

  // Byte-lane merge of the incoming beat onto the buffered word.
  always_comb begin
    merge_data_s = buf_data_q;
    for (int i = 0; i < STRB_W; i++) begin
      if (s_axi_wstrb[i]) begin
        merge_data_s[i*8 +: 8] = s_axi_wdata[i*8 +: 8];
      end else begin
        merge_data_s[i*8 +: 8] = buf_data_q[i*8 +: 8];
      end
    end
    merge_strb_s = buf_strb_q | s_axi_wstrb;
  end

  // Next-state and registered-output logic for both AXI sides.
  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_strb_d  = buf_strb_q;
    s_ready_d   = 1'b0;
    s_bvalid_d  = s_bvalid_q;
    s_bresp_d   = s_bresp_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
    err_d       = err_q;
`endif

    if (s_bvalid_q && s_axi_bready) begin
      s_bvalid_d = 1'b0;
      s_bresp_d  = RESP_OKAY;
    end else begin
      s_bvalid_d = s_bvalid_q;
    end

    case (state_q)
      IDLE, FILL: begin
        if (handshake_s) begin
          buf_addr_d = waddr_s;
          buf_data_d = merge_data_s;
          buf_strb_d = merge_strb_s;
          s_bvalid_d = 1'b1;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
          s_bresp_d  = err_q;
          err_d      = RESP_OKAY;
`else
          s_bresp_d  = RESP_OKAY;
`endif
          if (&merge_strb_s) begin
            state_d     = ISSUE;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else if ((state_q == FILL) &&
                     (tmr_expire_s || (eligible_s && (waddr_s != buf_addr_q)))) begin
          // Flush the partial word; a pending write to another word waits for IDLE.
          state_d     = ISSUE;
          m_awvalid_d = 1'b1;
          m_wvalid_d  = 1'b1;
        end else if (eligible_s) begin
          s_ready_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ISSUE: begin
        if (m_awvalid_q && m_axi_awready) begin
          m_awvalid_d = 1'b0;
        end else begin
          m_awvalid_d = m_awvalid_q;
        end
        if (m_wvalid_q && m_axi_wready) begin
          m_wvalid_d = 1'b0;
        end else begin
          m_wvalid_d = m_wvalid_q;
        end
        if (!m_awvalid_d && !m_wvalid_d) begin
          state_d    = RESP;
          m_bready_d = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          state_d    = IDLE;
          m_bready_d = 1'b0;
          buf_strb_d = '0;
          buf_data_d = '0;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
          if (m_axi_bresp != RESP_OKAY) begin
            err_d = m_axi_bresp;
          end else begin
            err_d = err_q;
          end
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      s_ready_q   <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= RESP_OKAY;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
      err_q       <= RESP_OKAY;
`endif
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_strb_q  <= buf_strb_d;
      s_ready_q   <= s_ready_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
      err_q       <= err_d;
`endif
    end
  end

  assign s_axi_awready = s_ready_q;
  assign s_axi_wready  = s_ready_q;
  assign s_axi_bvalid  = s_bvalid_q;
  assign s_axi_bresp   = s_bresp_q;
  assign m_axi_awaddr  = buf_addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = m_awvalid_q;
  assign m_axi_wdata   = buf_data_q;
  assign m_axi_wstrb   = buf_strb_q;
  assign m_axi_wvalid  = m_wvalid_q;
  assign m_axi_bready  = m_bready_q;

`ifdef AXI_W_PACKER_BRESP_FWD_EN
  assign unused_s = ^s_axi_awprot;
`else
  assign unused_s = ^{s_axi_awprot, m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_lite_w_packer.sv
// Directed scoreboard bench for axi_lite_w_packer (DATA_W=32, FLUSH_TIMEOUT=8).
module tb_axi_lite_w_packer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int TMO    = 8;
`ifdef AXI_W_PACKER_BRESP_FWD_EN
  localparam logic [1:0] FWD_ERR = 2'b10;
`else
  localparam logic [1:0] FWD_ERR = 2'b00;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mwr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid, s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wvalid, s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid, s_axi_bready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;

  mwr_t       m_exp_q[$];
  logic [1:0] b_exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs, vc;

  axi_lite_w_packer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  task automatic push_mwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mwr_t e;
    e.addr = addr;
    e.data = data & lane_mask(strb);
    e.strb = strb;
    m_exp_q.push_back(e);
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] data, input logic [1:0] exp_b);
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    b_exp_q.push_back(exp_b);
  endtask

  task automatic finish_write(output int hs_cyc);
    int n;
    logic [1:0] eb;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin
      tick();
      n++;
    end
    check("s_ready_pulse", {s_axi_awready, s_axi_wready}, 2'b11);
    hs_cyc = cyc;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("s_ready_drop", {s_axi_awready, s_axi_wready}, 2'b00);
    check("s_bvalid", s_axi_bvalid, 1'b1);
    eb = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : 2'b00;
    check("s_bresp", s_axi_bresp, eb);
  endtask

  task automatic serve_master(input int aw_dly, input int w_dly, input logic [1:0] resp,
                              output int v_cyc);
    int n;
    mwr_t e;
    logic aw_done, w_done;
    n = 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    while (!m_axi_awvalid && n < 50) begin
      tick();
      n++;
    end
    v_cyc = cyc;
    check("m_awvalid", m_axi_awvalid, 1'b1);
    check("m_wvalid", m_axi_wvalid, 1'b1);
    e = (m_exp_q.size() > 0) ? m_exp_q.pop_front() : '0;
    check("m_awaddr", m_axi_awaddr, e.addr);
    check("m_wstrb", m_axi_wstrb, e.strb);
    check("m_wdata", m_axi_wdata & lane_mask(e.strb), e.data);
    check("m_awprot", m_axi_awprot, 3'b000);
    check("m_bready_issue", m_axi_bready, 1'b0);
    for (int t = 0; t < 10 && !(aw_done && w_done); t++) begin
      m_axi_awready = !aw_done && (t >= aw_dly);
      m_axi_wready  = !w_done && (t >= w_dly);
      tick();
      if (m_axi_awready) aw_done = 1'b1;
      if (m_axi_wready)  w_done  = 1'b1;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      check("m_awvalid_hold", m_axi_awvalid, !aw_done);
      check("m_wvalid_hold", m_axi_wvalid, !w_done);
      check("m_bready_resp", m_axi_bready, aw_done && w_done);
    end
    m_axi_bresp  = resp;
    m_axi_bvalid = 1'b1;
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    check("m_bready_drop", m_axi_bready, 1'b0);
  endtask

  initial begin
    s_axi_awaddr = '0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (3) tick();

    check("rst_s_ready", {s_axi_awready, s_axi_wready}, 2'b00);
    check("rst_s_b", {s_axi_bvalid, s_axi_bresp}, 3'b000);
    check("rst_m_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    check("rst_m_strb", m_axi_wstrb, 4'b0000);
    check("rst_m_data", m_axi_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // Four single-byte writes to one word merge into one downstream write.
    push_mwr(32'h10, 32'hDDCCBBAA, 4'b1111);
    start_write(32'h10, 4'b0001, {4{8'hAA}}, 2'b00); finish_write(hs);
    start_write(32'h11, 4'b0010, {4{8'hBB}}, 2'b00); finish_write(hs);
    start_write(32'h12, 4'b0100, {4{8'hCC}}, 2'b00); finish_write(hs);
    check("no_early_issue", m_axi_awvalid, 1'b0);
    start_write(32'h13, 4'b1000, {4{8'hDD}}, 2'b00); finish_write(hs);
    serve_master(0, 0, 2'b00, vc);
    check("merge_latency", vc - hs, 1);

    // Address change flushes the partial word; downstream answers SLVERR.
    push_mwr(32'h10, 32'h12345678, 4'b0011);
    push_mwr(32'h20, 32'hCAFEF00D, 4'b1111);
    start_write(32'h10, 4'b0011, 32'h12345678, 2'b00); finish_write(hs);
    start_write(32'h20, 4'b1111, 32'hCAFEF00D, FWD_ERR);
    serve_master(0, 0, 2'b10, vc);
    finish_write(hs);
    serve_master(0, 0, 2'b00, vc);

    // Lone partial write is flushed by the idle timeout.
    push_mwr(32'h40, 32'h00770000, 4'b0100);
    start_write(32'h40, 4'b0100, 32'h11771111, 2'b00); finish_write(hs);
    serve_master(0, 0, 2'b00, vc);
    check("tmo_latency", vc - hs, TMO + 1);

    // W ready three cycles ahead of AW ready.
    push_mwr(32'h50, 32'h0BADBEEF, 4'b1111);
    start_write(32'h50, 4'b1111, 32'h0BADBEEF, 2'b00); finish_write(hs);
    serve_master(3, 0, 2'b00, vc);

    // Reset while the downstream write is outstanding.
    start_write(32'h60, 4'b1111, 32'h66666666, 2'b00); finish_write(hs);
    check("issue_before_rst", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_async_m", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    check("rst_async_s", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp}, 5'b00000);
    tick();
    rst = 1'b0;
    tick();
    push_mwr(32'h70, 32'h76543210, 4'b1111);
    start_write(32'h70, 4'b1111, 32'h76543210, 2'b00); finish_write(hs);
    serve_master(1, 1, 2'b00, vc);

    check("m_scoreboard_empty", m_exp_q.size(), 0);
    check("b_scoreboard_empty", b_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
